// File: rtl/mac_accumulator.sv
// Two-stage signed multiply-accumulate over last-delimited vectors.
// Define MAC_ACC_SAT_EN for a saturating accumulator with a sticky sat_o flag.
module mac_accumulator #(
   parameter int WIDTH_OPERAND = 16,
   parameter int WIDTH_ACC     = 32,
   parameter int WIDTH_COUNT   = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic signed [WIDTH_OPERAND-1:0] a_i,
   input  logic signed [WIDTH_OPERAND-1:0] b_i,
   input  logic                        in_last_i,
   input  logic                        in_valid_i,
   output logic                        in_ready_o,
   output logic signed [WIDTH_ACC-1:0] acc_o,
   output logic [WIDTH_COUNT-1:0]      cnt_o,
   output logic                        sat_o,
   output logic                        out_valid_o,
   input  logic                        out_ready_i
);
   localparam int WP = 2 * WIDTH_OPERAND;

   logic stall;
   logic accept;
   logic load;
   logic signed [WP-1:0] a_ext;
   logic signed [WP-1:0] b_ext;
   logic signed [WP-1:0] mul_p;
   logic mul_valid;
   logic mul_last;
   logic signed [WIDTH_ACC-1:0] acc;
   logic signed [WIDTH_ACC-1:0] base;
   logic signed [WIDTH_ACC-1:0] acc_next;
   logic [WIDTH_COUNT-1:0] cnt;
   logic [WIDTH_COUNT-1:0] cnt_next;
   logic first;

   assign stall      = out_valid_o && !out_ready_i;
   assign in_ready_o = !stall;
   assign accept     = in_valid_i && in_ready_o;
   assign load       = mul_valid && mul_last && !stall;

   assign a_ext = WP'(a_i);
   assign b_ext = WP'(b_i);

   // The first flag restarts the sum without inserting a bubble.
   assign base     = first ? '0 : acc;
   assign cnt_next = first ? WIDTH_COUNT'(1) : cnt + 1'b1;

`ifdef MAC_ACC_SAT_EN
   logic signed [WIDTH_ACC:0] sum;
   logic sat;
   logic sat_next;

   assign sum = (WIDTH_ACC+1)'(base) + (WIDTH_ACC+1)'(mul_p);

   always_comb begin
      acc_next = sum[WIDTH_ACC-1:0];
      sat_next = !first && sat;
      if (sum[WIDTH_ACC] != sum[WIDTH_ACC-1]) begin
         sat_next = 1'b1;
         if (sum[WIDTH_ACC])
            acc_next = {1'b1, {(WIDTH_ACC-1){1'b0}}};
         else
            acc_next = {1'b0, {(WIDTH_ACC-1){1'b1}}};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sat   <= 1'b0;
         sat_o <= 1'b0;
      end else if (!stall) begin
         if (mul_valid)
            sat <= sat_next;
         if (load)
            sat_o <= sat_next;
      end
   end
`else
   always_comb begin
      acc_next = base + WIDTH_ACC'(mul_p);
   end

   assign sat_o = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mul_valid   <= 1'b0;
         mul_p       <= '0;
         mul_last    <= 1'b0;
         acc         <= '0;
         cnt         <= '0;
         first       <= 1'b1;
         acc_o       <= '0;
         cnt_o       <= '0;
         out_valid_o <= 1'b0;
      end else if (!stall) begin
         mul_valid <= accept;
         if (accept) begin
            mul_p    <= a_ext * b_ext;
            mul_last <= in_last_i;
         end
         if (mul_valid) begin
            acc   <= acc_next;
            cnt   <= cnt_next;
            first <= mul_last;
         end
         // Not stalled: any pending result transfers now, a new load wins.
         out_valid_o <= load;
         if (load) begin
            acc_o <= acc_next;
            cnt_o <= cnt_next;
         end
      end
   end

endmodule

// File: tb/tb_mac_accumulator.sv
// Randomized scoreboard bench for mac_accumulator.
// Expected dot-products come from plain 64-bit arithmetic per vector.
module tb_mac_accumulator;
   localparam longint AMAX = 64'sd2147483647;
   localparam longint AMIN = -64'sd2147483648;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic signed [15:0] a = '0;
   logic signed [15:0] b = '0;
   logic last = 1'b0;
   logic in_valid = 1'b0;
   logic in_ready;
   logic signed [31:0] acc;
   logic [7:0] cnt;
   logic sat;
   logic out_valid;
   logic out_ready = 1'b1;

   typedef struct {
      logic signed [31:0] acc;
      logic [7:0]         cnt;
      logic               sat;
      int                 lat;
   } exp_t;

   exp_t sbq[$];
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int hold = 0;
   bit rdy_rand = 1'b0;
   bit lat_en = 1'b0;
   longint m_sum = 0;
   int m_cnt = 0;
   bit m_sat = 1'b0;

   mac_accumulator dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .a_i         (a),
      .b_i         (b),
      .in_last_i   (last),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .acc_o       (acc),
      .cnt_o       (cnt),
      .sat_o       (sat),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
      end
   endtask

   task automatic model_beat(input logic signed [15:0] ma, input logic signed [15:0] mb,
                             input bit ml, input int at);
      exp_t e;
      m_sum = m_sum + longint'(ma) * longint'(mb);
      m_cnt++;
`ifdef MAC_ACC_SAT_EN
      if (m_sum > AMAX) begin
         m_sum = AMAX;
         m_sat = 1'b1;
      end else if (m_sum < AMIN) begin
         m_sum = AMIN;
         m_sat = 1'b1;
      end
`endif
      if (ml) begin
         e.acc = m_sum[31:0];
         e.cnt = 8'(m_cnt);
         e.sat = m_sat;
         e.lat = lat_en ? at + 2 : -1;
         sbq.push_back(e);
         m_sum = 0;
         m_cnt = 0;
         m_sat = 1'b0;
      end
   endtask

   task automatic send(input logic signed [15:0] sa, input logic signed [15:0] sb, input bit sl);
      int n = 0;
      @(negedge clk);
      a = sa;
      b = sb;
      last = sl;
      in_valid = 1'b1;
      forever begin
         #2;
         if (in_ready) begin
            model_beat(sa, sb, sl, cyc);
            return;
         end
         n++;
         if (n > 200) begin
            check("send_timeout", 0, 1);
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", sbq.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_reset_state();
      check("rst_acc", acc, 0);
      check("rst_cnt", cnt, 0);
      check("rst_sat", sat, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
   endtask

   // Downstream readiness: forced-low hold window, else random or always ready.
   initial forever begin
      @(negedge clk);
      if (hold > 0) begin
         out_ready = 1'b0;
         hold--;
      end else if (rdy_rand) begin
         out_ready = ($urandom_range(0, 9) < 7);
      end else begin
         out_ready = 1'b1;
      end
   end

   // Monitor: the presented result must match the scoreboard head every cycle it is shown.
   initial forever begin
      exp_t e;
      @(negedge clk);
      #2;
      if (!rst_n) continue;
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid) begin
         if (sbq.size() == 0) begin
            check("unexpected_result", out_valid, 0);
         end else begin
            e = sbq[0];
            check("acc", acc, e.acc);
            check("cnt", cnt, e.cnt);
            check("sat", sat, e.sat);
            if (out_ready) begin
               if (e.lat >= 0)
                  check("latency_cycle", cyc, e.lat);
               void'(sbq.pop_front());
            end
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      #1;
      check_reset_state();
      @(negedge clk);
      rst_n = 1'b1;

      lat_en = 1'b1;
      for (int i = 0; i < 4; i++) send(16'sd512, 16'sd512, i == 3);
      idle(4);
      send(-16'sd512, 16'sd1024, 1'b1);
      idle(4);
      send(16'sd3, 16'sd4, 1'b0);
      send(16'sd5, 16'sd6, 1'b1);
      send(-16'sd1, 16'sd7, 1'b1);
      idle(4);
      send(-16'sd32768, -16'sd32768, 1'b0);
      send(-16'sd32768, -16'sd32768, 1'b1);
      idle(4);
      lat_en = 1'b0;

      hold = 8;
      send(16'sd1, 16'sd2, 1'b1);
      send(16'sd3, 16'sd3, 1'b0);
      send(16'sd4, 16'sd4, 1'b1);
      send(16'sd5, 16'sd5, 1'b1);
      send(-16'sd6, 16'sd5, 1'b1);
      idle(20);

      for (int i = 0; i < 258; i++) send(16'sd1, 16'sd1, i == 257);
      idle(4);
      drain();

      send(16'sd7, 16'sd7, 1'b0);
      send(16'sd9, 16'sd9, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      m_sum = 0;
      m_cnt = 0;
      m_sat = 1'b0;
      #1;
      check_reset_state();
      @(negedge clk);
      rst_n = 1'b1;
      send(16'sd2, 16'sd3, 1'b1);
      idle(6);

      rdy_rand = 1'b1;
      for (int v = 0; v < 60; v++) begin
         int len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) begin
            logic signed [15:0] ra = 16'($urandom);
            logic signed [15:0] rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) != 0) ? 16'sh8000 : 16'sh7fff;
            if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) != 0) ? 16'sh8000 : 16'sh7fff;
            send(ra, rb, i == len - 1);
            if ($urandom_range(0, 4) == 0) idle($urandom_range(0, 2));
         end
      end
      idle(2);
      rdy_rand = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
